// File: rtl/core_pkg.sv
// Shared core constants: register file geometry and data width.
// Imported by the register file, ALU and decoder.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int unsigned NUM_REGS   = 32;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: x0 mask, storage mux, optional bypass.
// addr_i selects from regs_i; wr_* carry the in-flight write for bypass; data_o is the read value.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic [ADDR_W-1:0]                  addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]   regs_i,
  input  logic                               wr_en_i,
  input  logic [ADDR_W-1:0]                  wr_addr_i,
  input  logic [DATA_W-1:0]                  wr_data_i,
  output logic [DATA_W-1:0]                  data_o
);

  logic is_zero;
  logic hit;

  assign is_zero = (addr_i == ADDR_W'(ZERO_REG));
  // wr_en_i is already qualified by reset and a non-zero write index
  assign hit     = BYPASS && wr_en_i && (wr_addr_i == addr_i);

  always_comb begin
    data_o = regs_i[addr_i];
    unique case (1'b1)
      is_zero: data_o = '0;
      hit:     data_o = wr_data_i;
      default: data_o = regs_i[addr_i];
    endcase
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 2 read ports, 1 write port, debug read, x0 = 0.
// Ports: clk, rst (async active-low), A1/A2 -> RD1/RD2, A3/WD3/WE3 write, DbgA -> DbgRD.
module register_file
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] DbgA,
  output logic [DATA_W-1:0] DbgRD
);

  localparam int unsigned NREGS = 2**ADDR_W;

  // x0 has no storage; entries 1..NREGS-1 only
  logic [NREGS-1:1][DATA_W-1:0] regs_q;
  logic [NREGS-1:1][DATA_W-1:0] regs_d;
  logic [NREGS-1:0][DATA_W-1:0] regs_rd;
  logic                         wr_en;

  // rst gates the bypass so reads stay 0 while in reset
  assign wr_en   = rst && WE3 && (A3 != ADDR_W'(ZERO_REG));
  assign regs_rd = {regs_q, {DATA_W{1'b0}}};

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wr_en && (A3 == ADDR_W'(i))) begin
        regs_d[i] = WD3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .addr_i    (A1),
    .regs_i    (regs_rd),
    .wr_en_i   (wr_en),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
    .data_o    (RD1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd2 (
    .addr_i    (A2),
    .regs_i    (regs_rd),
    .wr_en_i   (wr_en),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
    .data_o    (RD2)
  );

  // Debug view shows committed state only
  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (1'b0)
  ) u_dbg (
    .addr_i    (DbgA),
    .regs_i    (regs_rd),
    .wr_en_i   (1'b0),
    .wr_addr_i ('0),
    .wr_data_i ('0),
    .data_o    (DbgRD)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: unbypassed and bypassed builds side by side.
// Both instances share inputs; expected values are hand-computed constants.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1, A2, A3, DbgA;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] rd1_n, rd2_n, dbg_n;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] alu_res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .WE3(WE3),
    .RD1(rd1_n), .RD2(rd2_n),
    .DbgA(DbgA), .DbgRD(dbg_n)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_by (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .WE3(WE3),
    .RD1(rd1_b), .RD2(rd2_b),
    .DbgA(DbgA), .DbgRD(dbg_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A3  = a;
    WD3 = d;
    WE3 = 1'b1;
    tick();
    WE3 = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    WE3 = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; DbgA = '0;
    WD3 = '0;
    #2;
    A1 = 5'd5; A2 = 5'd31; DbgA = 5'd12;
    #1;
    check("rst_rd1", rd1_n, 32'h0);
    check("rst_rd2", rd2_n, 32'h0);
    check("rst_dbg", dbg_n, 32'h0);
    // bypass must be gated while in reset
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h1234_5678;
    #1;
    check("rst_byp_rd1", rd1_b, 32'h0);
    WE3 = 1'b0;
    tick();
    check("rst_no_write", dbg_n, 32'h0);
    rst = 1'b1;
    #1;

    // pre-fill every register, then reset clear
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h0101_0101 * i);
    DbgA = 5'd31;
    #1;
    check("prefill_x31", dbg_n, 32'h1F1F_1F1F);
    DbgA = 5'd6;
    #1;
    check("prefill_x6", dbg_b, 32'h0606_0606);
    rst = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      DbgA = 5'(i);
      #1;
      check($sformatf("clr_dbg_x%0d", i), dbg_n, 32'h0);
    end
    A1 = 5'd5; A2 = 5'd31;
    #1;
    check("clr_rd1", rd1_n, 32'h0);
    check("clr_rd2", rd2_b, 32'h0);
    rst = 1'b1;
    #1;

    // write/read
    wr(5'd7, 32'hDEAD_BEEF);
    A1 = 5'd7; A2 = 5'd8;
    #1;
    check("wr_rd1", rd1_n, 32'hDEAD_BEEF);
    check("wr_rd2", rd2_n, 32'h0);

    // x0 immutability
    A1 = 5'd0; A3 = 5'd0; WD3 = 32'hFFFF_FFFF; WE3 = 1'b1;
    #1;
    check("x0_byp_rd1", rd1_b, 32'h0);
    tick();
    WE3 = 1'b0;
    #1;
    check("x0_rd1", rd1_n, 32'h0);
    DbgA = 5'd7;
    #1;
    check("x0_x7", dbg_n, 32'hDEAD_BEEF);
    DbgA = 5'd1;
    #1;
    check("x0_x1", dbg_n, 32'h0);

    // bypass
    wr(5'd3, 32'd10);
    A1 = 5'd3; A2 = 5'd3; A3 = 5'd3; DbgA = 5'd3;
    WD3 = 32'd15; WE3 = 1'b1;
    #1;
    check("nb_rd1_pre", rd1_n, 32'd10);
    check("by_rd1_pre", rd1_b, 32'd15);
    check("by_rd2_pre", rd2_b, 32'd15);
    check("nb_dbg_pre", dbg_n, 32'd10);
    check("by_dbg_pre", dbg_b, 32'd10);
    tick();
    WE3 = 1'b0;
    #1;
    check("nb_rd1_post", rd1_n, 32'd15);
    check("by_rd1_post", rd1_b, 32'd15);

    // reads to a different index do not see the write
    A1 = 5'd7; A3 = 5'd9; WD3 = 32'd77; WE3 = 1'b1;
    #1;
    check("by_noint", rd1_b, 32'hDEAD_BEEF);
    WE3 = 1'b0;

    // back-to-back writes
    DbgA = 5'd9;
    wr(5'd9, 32'd1);
    check("b2b_1", dbg_n, 32'd1);
    wr(5'd9, 32'd2);
    check("b2b_2", dbg_n, 32'd2);

    // async reset mid-write
    wr(5'd4, 32'h55);
    DbgA = 5'd4;
    #1;
    check("ar_pre", dbg_n, 32'h55);
    A3 = 5'd4; WD3 = 32'hAA; WE3 = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("ar_imm", dbg_n, 32'h0);
    tick();
    check("ar_edge", dbg_b, 32'h0);
    WE3 = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    check("ar_after", dbg_n, 32'h0);

    // ALU integration (ALUControl 001 = subtract)
    wr(5'd1, 32'd15);
    wr(5'd2, 32'd10);
    A1 = 5'd1; A2 = 5'd2;
    #1;
    alu_res = rd1_n - rd2_n;
    check("alu_res", alu_res, 32'd5);
    wr(5'd3, alu_res);
    A1 = 5'd3;
    #1;
    check("alu_wb", rd1_n, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
